// File: rtl/grid_position_tracker.sv
// Registered (x, y) cell position on a bounded grid, stepped every TICK_DIV cycles
// from a 4-bit direction word; edges either wrap or halt with a sticky collision.
module grid_position_tracker #(
    parameter int unsigned COLS     = 16,
    parameter int unsigned ROWS     = 12,
    parameter int unsigned XW       = 4,
    parameter int unsigned YW       = 4,
    parameter int unsigned X0       = 0,
    parameter int unsigned Y0       = 0,
    parameter int unsigned TICK_DIV = 4,
    parameter bit          WRAP     = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pause,
    input  logic          restart,
    input  logic [3:0]    dir_in,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic          step_pulse,
    output logic          collision,
    output logic          running
);

    localparam int unsigned PW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned XEW = XW + 1;
    localparam int unsigned YEW = YW + 1;

    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [XEW-1:0] X_LIM    = XEW'(COLS);
    localparam logic [YEW-1:0] Y_LIM    = YEW'(ROWS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          step_q, step_d;
    logic          col_q, col_d;
    logic          run_q, run_d;

    logic [XEW-1:0] x_inc, x_dec;
    logic [YEW-1:0] y_inc, y_dec;
    logic [XW-1:0]  x_mv;
    logic [YW-1:0]  y_mv;
    logic           x_hit, y_hit;

    // Candidate next position per axis, widened one bit so edges are explicit
    always_comb begin
        x_inc = XEW'(x_q) + XEW'(1);
        x_dec = XEW'(x_q) - XEW'(1);
        x_hit = 1'b0;
        x_mv  = x_q;
        if (dir_in[0]) begin
            if (dir_in[1]) begin
                if (x_inc >= X_LIM) begin
                    x_hit = 1'b1;
                    x_mv  = XW'(0);
                end else begin
                    x_mv = x_inc[XW-1:0];
                end
            end else begin
                if (x_dec[XW]) begin
                    x_hit = 1'b1;
                    x_mv  = XW'(COLS - 1);
                end else begin
                    x_mv = x_dec[XW-1:0];
                end
            end
        end
    end

    always_comb begin
        y_inc = YEW'(y_q) + YEW'(1);
        y_dec = YEW'(y_q) - YEW'(1);
        y_hit = 1'b0;
        y_mv  = y_q;
        if (dir_in[2]) begin
            if (dir_in[3]) begin
                if (y_inc >= Y_LIM) begin
                    y_hit = 1'b1;
                    y_mv  = YW'(0);
                end else begin
                    y_mv = y_inc[YW-1:0];
                end
            end else begin
                if (y_dec[YW]) begin
                    y_hit = 1'b1;
                    y_mv  = YW'(ROWS - 1);
                end else begin
                    y_mv = y_dec[YW-1:0];
                end
            end
        end
    end

    // Next-state, prescaler and step logic; restart overrides everything
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        x_d     = x_q;
        y_d     = y_q;
        step_d  = 1'b0;
        col_d   = col_q;
        if (restart) begin
            state_d = S_IDLE;
            pre_d   = '0;
            x_d     = XW'(X0);
            y_d     = YW'(Y0);
            col_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        pre_d   = '0;
                    end
                end
                S_RUN: begin
                    if (!pause) begin
                        if (pre_q == PRE_LAST) begin
                            pre_d  = '0;
                            step_d = 1'b1;
                            if (!WRAP && (x_hit || y_hit)) begin
                                col_d   = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                x_d = x_mv;
                                y_d = y_mv;
                            end
                        end else begin
                            pre_d = pre_q + PW'(1);
                        end
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        run_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            x_q     <= XW'(X0);
            y_q     <= YW'(Y0);
            step_q  <= 1'b0;
            col_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            x_q     <= x_d;
            y_q     <= y_d;
            step_q  <= step_d;
            col_q   <= col_d;
            run_q   <= run_d;
        end
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign step_pulse = step_q;
    assign collision  = col_q;
    assign running    = run_q;

endmodule

// File: tb/tb_grid_position_tracker.sv
// Bench for grid_position_tracker: a wrapping and a halting instance share stimulus
// and are checked every cycle against a behavioural grid model plus literal checkpoints.
module tb_grid_position_tracker;

    localparam int COLS = 16;
    localparam int ROWS = 12;
    localparam int TICK = 4;
    localparam int X0   = 0;
    localparam int Y0   = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       restart = 1'b0;
    logic [3:0] dir_in = 4'b0000;

    logic [3:0] xo   [2];
    logic [3:0] yo   [2];
    logic       stp  [2];
    logic       col  [2];
    logic       run  [2];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    // index 0: WRAP=1, index 1: WRAP=0
    grid_position_tracker #(.WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .restart(restart),
        .dir_in(dir_in), .x_out(xo[0]), .y_out(yo[0]), .step_pulse(stp[0]),
        .collision(col[0]), .running(run[0])
    );

    grid_position_tracker #(.WRAP(1'b0)) u_halt (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .restart(restart),
        .dir_in(dir_in), .x_out(xo[1]), .y_out(yo[1]), .step_pulse(stp[1]),
        .collision(col[1]), .running(run[1])
    );

    always #5 clk = ~clk;

    // Behavioural model: steps counted as multiples of TICK unpaused run cycles
    int mx [2], my [2], mcnt [2];
    bit mrun [2], mhalt [2], mcol [2], mstep [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                mx[m] = X0; my[m] = Y0; mcnt[m] = 0;
                mrun[m] = 0; mhalt[m] = 0; mcol[m] = 0; mstep[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                mstep[m] = 0;
                if (restart) begin
                    mx[m] = X0; my[m] = Y0; mcnt[m] = 0;
                    mrun[m] = 0; mhalt[m] = 0; mcol[m] = 0;
                end else if (mrun[m]) begin
                    if (!pause) begin
                        mcnt[m]++;
                        if (mcnt[m] % TICK == 0) begin
                            int dx, dy, nx, ny;
                            dx = dir_in[0] ? (dir_in[1] ? 1 : -1) : 0;
                            dy = dir_in[2] ? (dir_in[3] ? 1 : -1) : 0;
                            nx = mx[m] + dx;
                            ny = my[m] + dy;
                            mstep[m] = 1;
                            if (m == 0) begin
                                mx[m] = (nx + COLS) % COLS;
                                my[m] = (ny + ROWS) % ROWS;
                            end else if (nx < 0 || nx >= COLS || ny < 0 || ny >= ROWS) begin
                                mcol[m] = 1; mrun[m] = 0; mhalt[m] = 1;
                            end else begin
                                mx[m] = nx; my[m] = ny;
                            end
                        end
                    end
                end else if (!mhalt[m] && start) begin
                    mrun[m] = 1;
                    mcnt[m] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int m, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, m, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int m = 0; m < 2; m++) begin
                chk("model_x", m, int'(xo[m]), mx[m]);
                chk("model_y", m, int'(yo[m]), my[m]);
                chk("model_step", m, int'(stp[m]), int'(mstep[m]));
                chk("model_collision", m, int'(col[m]), int'(mcol[m]));
                chk("model_running", m, int'(run[m]), int'(mrun[m]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        start   = 1'b0;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        int cyc;
        repeat (2) tick();
        rst = 1'b0;
        chk_on = 1'b1;
        tick();
        for (int m = 0; m < 2; m++) begin
            chk("reset_x", m, int'(xo[m]), 0);
            chk("reset_running", m, int'(run[m]), 0);
            chk("reset_collision", m, int'(col[m]), 0);
        end

        // x increments at 4, 8, 12 cycles after start
        start = 1'b1; dir_in = 4'b0011;
        tick();
        chk("start_running", 0, int'(run[0]), 1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("inc_step", 0, int'(stp[0]), (i % 4 == 0) ? 1 : 0);
            chk("inc_x", 0, int'(xo[0]), i / 4);
        end
        chk("inc_y", 0, int'(yo[0]), 0);

        // left edge at x=0: wrap vs halt
        do_restart();
        chk("restart_x", 1, int'(xo[1]), 0);
        chk("restart_running", 1, int'(run[1]), 0);
        start = 1'b1; dir_in = 4'b0001;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("wrap_left_x", 0, int'(xo[0]), 15);
        chk("wrap_left_col", 0, int'(col[0]), 0);
        chk("halt_left_x", 1, int'(xo[1]), 0);
        chk("halt_left_col", 1, int'(col[1]), 1);
        chk("halt_left_run", 1, int'(run[1]), 0);
        chk("halt_left_step", 1, int'(stp[1]), 1);
        dir_in = 4'b0100;
        repeat (4) tick();
        chk("wrap_down_y", 0, int'(yo[0]), 11);
        chk("wrap_down_x", 0, int'(xo[0]), 15);
        chk("halt_no_step", 1, int'(stp[1]), 0);
        do_restart();
        chk("restart_col", 1, int'(col[1]), 0);

        // diagonal moves, then right edge at (15,5)
        start = 1'b1; dir_in = 4'b1111;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("diag_x2", 1, int'(xo[1]), 2);
        chk("diag_y2", 1, int'(yo[1]), 2);
        repeat (4) tick();
        chk("diag_x3", 1, int'(xo[1]), 3);
        chk("diag_y3", 1, int'(yo[1]), 3);
        repeat (8) tick();
        dir_in = 4'b0011;
        repeat (40) tick();
        chk("edge_x", 1, int'(xo[1]), 15);
        chk("edge_y", 1, int'(yo[1]), 5);
        dir_in = 4'b1011;
        repeat (4) tick();
        chk("halt_right_x", 1, int'(xo[1]), 15);
        chk("halt_right_y", 1, int'(yo[1]), 5);
        chk("halt_right_col", 1, int'(col[1]), 1);
        chk("wrap_right_x", 0, int'(xo[0]), 0);
        chk("wrap_right_y", 0, int'(yo[0]), 5);

        // pause for 3 cycles stretches spacing to 7; dir changes off-step ignored
        do_restart();
        start = 1'b1; dir_in = 4'b0011;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pause_first_x", 0, int'(xo[0]), 1);
        tick();
        cyc = 1;
        pause = 1'b1; dir_in = 4'b0001;
        repeat (3) tick();
        cyc += 3;
        pause = 1'b0; dir_in = 4'b0011;
        while (cyc < 30) begin
            tick();
            cyc++;
            if (stp[0]) break;
        end
        chk("pause_spacing", 0, cyc, 7);
        chk("pause_x", 0, int'(xo[0]), 2);

        // async reset two cycles into a step period
        repeat (2) tick();
        #3 rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("async_rst_x", m, int'(xo[m]), 0);
            chk("async_rst_running", m, int'(run[m]), 0);
        end
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("post_rst_idle", 0, int'(run[0]), 0);

        // randomized traffic
        repeat (3000) begin
            start   = ($urandom_range(0, 9) < 3);
            pause   = ($urandom_range(0, 3) == 0);
            restart = ($urandom_range(0, 49) == 0);
            dir_in  = 4'($urandom);
            rst     = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; pause = 1'b0; restart = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
